// File: rtl/mem_access.sv
// Memory stage of the 5-stage MIPS pipeline: E->M register, split-handshake data bus
// master with stall generation, and load alignment / extension.
module mem_access #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              StallM,
    input  logic              FlushM,
    input  logic [DATA_W-1:0] PCE,
    input  logic              RegWriteE,
    input  logic              MemtoRegE,
    input  logic              MemWriteE,
    input  logic              SignedE,
    input  logic [2:0]        SizeE,
    input  logic [DATA_W-1:0] ALUOutE,
    input  logic [DATA_W-1:0] WriteDataE,
    input  logic [REG_W-1:0]  WriteRegE,
    output logic [DATA_W-1:0] PCM,
    output logic              RegWriteM,
    output logic              MemtoRegM,
    output logic [REG_W-1:0]  WriteRegM,
    output logic [DATA_W-1:0] ALUOutM,
    output logic [DATA_W-1:0] ReadDataM,
    output logic              MemStallM,
    output logic              dreq_valid,
    output logic [DATA_W-1:0] dreq_addr,
    output logic [2:0]        dreq_size,
    output logic [3:0]        dreq_strobe,
    output logic [DATA_W-1:0] dreq_data,
    input  logic              dresp_addr_ok,
    input  logic              dresp_data_ok,
    input  logic [DATA_W-1:0] dresp_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_pc;
    logic                r_regwrite;
    logic                r_memtoreg;
    logic                r_memwrite;
    logic                r_signed;
    logic [2:0]          r_size;
    logic [DATA_W-1:0]   r_aluout;
    logic [DATA_W-1:0]   r_wdata;
    logic [REG_W-1:0]    r_wreg;
    logic [DATA_W-1:0]   r_rdata;

    logic                w_access;
    logic                w_capture;
    logic [1:0]          w_a;
    logic [4:0]          w_lshamt;
    logic [DATA_W-1:0]   w_shifted;
    logic [DATA_W-1:0]   w_load;
    logic [3:0]          w_strobe;
    logic [DATA_W-1:0]   w_sdata;

    assign w_access = r_memtoreg | r_memwrite;
    assign w_a      = r_aluout[1:0];

    // E->M pipeline register; a flush only clears the side-effecting controls
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pc       <= '0;
            r_regwrite <= 1'b0;
            r_memtoreg <= 1'b0;
            r_memwrite <= 1'b0;
            r_signed   <= 1'b0;
            r_size     <= 3'd0;
            r_aluout   <= '0;
            r_wdata    <= '0;
            r_wreg     <= '0;
        end else if (!StallM) begin
            r_pc       <= PCE;
            r_regwrite <= RegWriteE & ~FlushM;
            r_memtoreg <= MemtoRegE & ~FlushM;
            r_memwrite <= MemWriteE & ~FlushM;
            r_signed   <= SignedE;
            r_size     <= SizeE;
            r_aluout   <= ALUOutE;
            r_wdata    <= WriteDataE;
            r_wreg     <= WriteRegE;
        end else begin
            r_pc       <= r_pc;
            r_regwrite <= r_regwrite;
            r_memtoreg <= r_memtoreg;
            r_memwrite <= r_memwrite;
            r_signed   <= r_signed;
            r_size     <= r_size;
            r_aluout   <= r_aluout;
            r_wdata    <= r_wdata;
            r_wreg     <= r_wreg;
        end
    end

    // Bus FSM state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Bus FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_REQ: begin
                if (!w_access) begin
                    w_state_nxt = S_IDLE;
                end else if (dresp_addr_ok && dresp_data_ok) begin
                    w_state_nxt = S_DONE;
                end else if (dresp_addr_ok) begin
                    w_state_nxt = S_WAIT;
                end else begin
                    w_state_nxt = S_REQ;
                end
            end
            S_WAIT: begin
                if (dresp_data_ok) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_DONE: begin
                if (!StallM) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Bus FSM outputs
    always_comb begin
        dreq_valid = 1'b0;
        MemStallM  = 1'b0;
        if (w_access) begin
            dreq_valid = (r_state == S_IDLE) || (r_state == S_REQ);
            MemStallM  = (r_state != S_DONE);
        end else begin
            dreq_valid = 1'b0;
            MemStallM  = 1'b0;
        end
    end

    // Only a response belonging to the outstanding request is captured
    assign w_capture = w_access && dresp_data_ok &&
                       ((((r_state == S_IDLE) || (r_state == S_REQ)) && dresp_addr_ok) ||
                        (r_state == S_WAIT));

    // Lane selection, strobes and store replication
    always_comb begin
        w_lshamt = 5'd0;
        w_strobe = 4'b0000;
        w_sdata  = r_wdata;
        case (r_size)
            3'd0: begin
                w_lshamt = {w_a, 3'b000};
                w_strobe = 4'b0001 << w_a;
                w_sdata  = {4{r_wdata[7:0]}};
            end
            3'd1: begin
                w_lshamt = {w_a[1], 1'b0, 3'b000};
                w_strobe = 4'b0011 << {w_a[1], 1'b0};
                w_sdata  = {2{r_wdata[15:0]}};
            end
            default: begin
                w_lshamt = 5'd0;
                w_strobe = 4'b1111;
                w_sdata  = r_wdata;
            end
        endcase
        if (!r_memwrite) begin
            w_strobe = 4'b0000;
        end else begin
            w_strobe = w_strobe;
        end
    end

    assign w_shifted = dresp_data >> w_lshamt;

    // Load extension
    always_comb begin
        w_load = w_shifted;
        case (r_size)
            3'd0:    w_load = {{(DATA_W-8){r_signed & w_shifted[7]}}, w_shifted[7:0]};
            3'd1:    w_load = {{(DATA_W-16){r_signed & w_shifted[15]}}, w_shifted[15:0]};
            default: w_load = w_shifted;
        endcase
    end

    // Read data register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rdata <= '0;
        end else if (w_capture) begin
            r_rdata <= w_load;
        end else begin
            r_rdata <= r_rdata;
        end
    end

    assign PCM         = r_pc;
    assign RegWriteM   = r_regwrite;
    assign MemtoRegM   = r_memtoreg;
    assign WriteRegM   = r_wreg;
    assign ALUOutM     = r_aluout;
    assign ReadDataM   = r_rdata;
    assign dreq_addr   = {r_aluout[DATA_W-1:2], 2'b00};
    assign dreq_size   = r_size;
    assign dreq_strobe = w_strobe;
    assign dreq_data   = w_sdata;

endmodule

// File: tb/tb_mem_access.sv
// Randomized scoreboard bench for mem_access: stimulus pushes expected M-stage contents,
// a monitor pops and checks them as each instruction leaves M.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        StallM, FlushM, ext_stall;
    logic [31:0] PCE, ALUOutE, WriteDataE;
    logic        RegWriteE, MemtoRegE, MemWriteE, SignedE;
    logic [2:0]  SizeE;
    logic [4:0]  WriteRegE;
    logic [31:0] PCM, ALUOutM, ReadDataM, dreq_addr, dreq_data, dresp_data;
    logic        RegWriteM, MemtoRegM, MemStallM, dreq_valid;
    logic [4:0]  WriteRegM;
    logic [2:0]  dreq_size;
    logic [3:0]  dreq_strobe;
    logic        dresp_addr_ok, dresp_data_ok;

    logic        rsp_aok, rsp_dok, dir_aok, dir_dok;
    logic [31:0] rsp_dat, dir_dat;
    bit          run_rand = 1'b0;
    bit          drain = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;

    typedef struct {
        logic [31:0] pc;
        logic        rw, m2r, mw, sgn;
        logic [2:0]  size;
        logic [31:0] alu, wdata, raw;
        logic [4:0]  wreg;
    } rec_t;

    rec_t q[$];

    always #5 clk = ~clk;

    assign StallM        = ext_stall | MemStallM;
    assign dresp_addr_ok = run_rand ? rsp_aok : dir_aok;
    assign dresp_data_ok = run_rand ? rsp_dok : dir_dok;
    assign dresp_data    = run_rand ? rsp_dat : dir_dat;

    mem_access #(.DATA_W(32), .REG_W(5)) dut (
        .clk(clk), .resetn(resetn), .StallM(StallM), .FlushM(FlushM),
        .PCE(PCE), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
        .SignedE(SignedE), .SizeE(SizeE), .ALUOutE(ALUOutE), .WriteDataE(WriteDataE),
        .WriteRegE(WriteRegE), .PCM(PCM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
        .WriteRegM(WriteRegM), .ALUOutM(ALUOutM), .ReadDataM(ReadDataM),
        .MemStallM(MemStallM), .dreq_valid(dreq_valid), .dreq_addr(dreq_addr),
        .dreq_size(dreq_size), .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok),
        .dresp_data(dresp_data)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: access width in bytes and lowest byte lane touched
    function automatic int nbytes(input logic [2:0] s);
        case (s)
            3'd0:    return 1;
            3'd1:    return 2;
            default: return 4;
        endcase
    endfunction

    function automatic int lane_base(input rec_t r);
        int a = int'(r.alu[1:0]);
        int n = nbytes(r.size);
        return a - (a % n);
    endfunction

    function automatic logic [3:0] exp_strobe(input rec_t r);
        logic [3:0] s = 4'b0000;
        int b = lane_base(r);
        int n = nbytes(r.size);
        if (r.mw) begin
            for (int i = 0; i < 4; i++) begin
                if (i >= b && i < b + n) s[i] = 1'b1;
            end
        end
        return s;
    endfunction

    function automatic logic [31:0] exp_sdata(input rec_t r);
        logic [31:0] d = 32'd0;
        int n = nbytes(r.size);
        for (int i = 0; i < 4; i++) d[8*i +: 8] = r.wdata[8*(i % n) +: 8];
        return d;
    endfunction

    function automatic logic [31:0] exp_load(input rec_t r);
        longint v = 0;
        int b = lane_base(r);
        int n = nbytes(r.size);
        for (int k = 0; k < n; k++) v += longint'(r.raw[8*(b+k) +: 8]) << (8*k);
        if (r.sgn && n < 4 && v >= (longint'(1) << (8*n - 1))) v -= longint'(1) << (8*n);
        return 32'(v);
    endfunction

    task automatic drive_cycle(input bit rnd);
        rec_t r;
        int kind;
        kind       = rnd ? int'($urandom_range(0, 3)) : 3;
        PCE        = $urandom;
        ALUOutE    = $urandom;
        WriteDataE = $urandom;
        WriteRegE  = 5'($urandom);
        SizeE      = 3'($urandom_range(0, 2));
        SignedE    = 1'($urandom);
        RegWriteE  = (kind == 0) || (kind == 1);
        MemtoRegE  = (kind == 1);
        MemWriteE  = (kind == 2);
        FlushM     = rnd && ($urandom_range(0, 6) == 0);
        ext_stall  = rnd && ($urandom_range(0, 4) == 0);
        @(negedge clk);
        if (!StallM) begin
            r.pc = PCE; r.alu = ALUOutE; r.wdata = WriteDataE; r.wreg = WriteRegE;
            r.size = SizeE; r.sgn = SignedE; r.raw = $urandom;
            r.rw  = RegWriteE & ~FlushM;
            r.m2r = MemtoRegE & ~FlushM;
            r.mw  = MemWriteE & ~FlushM;
            q.push_back(r);
        end
        @(posedge clk);
        #1;
    endtask

    // Bus responder: random accept/response delays plus stray data_ok pulses
    initial begin
        bit pend = 1'b0;
        int dly = 0;
        rsp_aok = 1'b0; rsp_dok = 1'b0; rsp_dat = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            rsp_aok = 1'b0; rsp_dok = 1'b0; rsp_dat = $urandom;
            if (!resetn || q.size() == 0) begin
                pend = 1'b0;
            end else if (pend) begin
                if (dly == 0) begin
                    rsp_dok = 1'b1; rsp_dat = q[0].raw; pend = 1'b0;
                end else begin
                    dly--;
                end
            end else if (dreq_valid) begin
                if (drain || $urandom_range(0, 2) == 0) begin
                    rsp_aok = 1'b1;
                    if (drain || $urandom_range(0, 1) == 0) begin
                        rsp_dok = 1'b1; rsp_dat = q[0].raw;
                    end else begin
                        pend = 1'b1; dly = $urandom_range(0, 3);
                    end
                end
            end else if ($urandom_range(0, 9) == 0) begin
                rsp_dok = 1'b1;
            end
        end
    end

    // Monitor: checks bus requests every cycle and M contents as they leave the stage
    initial begin
        int acc_cnt = 0;
        rec_t cur;
        bit acc;
        forever begin
            @(negedge clk);
            if (run_rand) begin
                if (q.size() == 0) begin
                    check("queue_nonempty", 64'(q.size()), 64'd1);
                end else begin
                    cur = q[0];
                    acc = cur.m2r | cur.mw;
                    if (dreq_valid) begin
                        check("req_needs_access", 64'(acc), 64'd1);
                        check("req_fields", 64'({dreq_addr, dreq_size, dreq_strobe}),
                              64'({cur.alu & 32'hFFFF_FFFC, cur.size, exp_strobe(cur)}));
                        if (cur.mw) check("req_wdata", 64'(dreq_data), 64'(exp_sdata(cur)));
                        if (dresp_addr_ok) acc_cnt++;
                    end
                    if (!acc) check("no_stall", 64'(MemStallM), 64'd0);
                    if (!StallM) begin
                        check("m_regs", 64'({PCM, RegWriteM, MemtoRegM, WriteRegM}),
                              64'({cur.pc, cur.rw, cur.m2r, cur.wreg}));
                        check("aluout", 64'(ALUOutM), 64'(cur.alu));
                        check("accepts", 64'(acc_cnt), acc ? 64'd1 : 64'd0);
                        if (cur.m2r) check("load_data", 64'(ReadDataM), 64'(exp_load(cur)));
                        void'(q.pop_front());
                        acc_cnt = 0;
                    end
                end
            end
        end
    end

    initial begin
        rec_t bubble;
        bubble = '{pc: 32'd0, rw: 1'b0, m2r: 1'b0, mw: 1'b0, sgn: 1'b0, size: 3'd0,
                   alu: 32'd0, wdata: 32'd0, raw: 32'd0, wreg: 5'd0};
        PCE = 32'd0; ALUOutE = 32'd0; WriteDataE = 32'd0; WriteRegE = 5'd0; SizeE = 3'd0;
        SignedE = 1'b0; RegWriteE = 1'b0; MemtoRegE = 1'b0; MemWriteE = 1'b0;
        FlushM = 1'b0; ext_stall = 1'b0;
        dir_aok = 1'b0; dir_dok = 1'b0; dir_dat = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", 64'({dreq_valid, MemStallM, ReadDataM, dreq_strobe}), 64'd0);
        resetn = 1'b1;
        q.push_back(bubble);
        run_rand = 1'b1;
        for (int c = 0; c < 3000; c++) drive_cycle(1'b1);
        drain = 1'b1;
        for (int c = 0; c < 30; c++) drive_cycle(1'b0);
        check("drain_idle", 64'(MemStallM), 64'd0);
        run_rand = 1'b0;

        // Directed: reset while waiting for read data, then a stray response
        MemtoRegE = 1'b1; RegWriteE = 1'b1; SizeE = 3'd2; ALUOutE = 32'h0000_0100;
        @(posedge clk);
        #1;
        MemtoRegE = 1'b0; RegWriteE = 1'b0;
        check("dir_valid", 64'({dreq_valid, MemStallM, dreq_addr}), 64'({2'b11, 32'h100}));
        dir_aok = 1'b1;
        @(posedge clk);
        #1;
        dir_aok = 1'b0;
        check("dir_wait", 64'({dreq_valid, MemStallM}), 64'({2'b01}));
        resetn = 1'b0;
        #1;
        check("rst_bus", 64'({dreq_valid, MemStallM, dreq_strobe, dreq_addr}), 64'd0);
        check("rst_regs", 64'({MemtoRegM, RegWriteM, ALUOutM}), 64'd0);
        check("rst_rdata", 64'(ReadDataM), 64'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        dir_dok = 1'b1; dir_dat = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        dir_dok = 1'b0;
        check("stray_rdata", 64'({ReadDataM, MemStallM}), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
